// File: rtl/ex_mem_pipe_buffer_pkg.sv
// ============================================================================
// Module : ex_mem_pipe_buffer_pkg
// Brief  : Shared constants and state encoding for the EX->MEM pipe buffer.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package ex_mem_pipe_buffer_pkg;

  localparam logic ENABLE  = 1'b1;
  localparam logic DISABLE = 1'b0;

  localparam int REGS_ADDR_WIDTH = 5;
  localparam int REGS_DATA_WIDTH = 32;

  localparam logic [REGS_DATA_WIDTH-1:0] ZERO_WORD = '0;

  typedef enum logic [1:0] {
    BUF_EMPTY = 2'd0,
    BUF_ONE   = 2'd1,
    BUF_FULL  = 2'd2
  } buf_state_e;

endpackage

`default_nettype wire

// File: rtl/ex_mem_pipe_buffer_payload_reg.sv
// ============================================================================
// Module : pipe_payload_reg
// Brief  : One payload register with load-enable; clear wins over load.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module pipe_payload_reg #(
  parameter int WIDTH = 8
) (
  input  logic             clock,
  input  logic             clear,
  input  logic             load,
  input  logic [WIDTH-1:0] d_in,
  output logic [WIDTH-1:0] q_out
);

  logic [WIDTH-1:0] data_d;
  logic [WIDTH-1:0] data_q;

  always_comb begin
    data_d = data_q;
    if (clear) begin
      data_d = '0;
    end else if (load) begin
      data_d = d_in;
    end
  end

  always_ff @(posedge clock) begin
    data_q <= data_d;
  end

  assign q_out = data_q;

endmodule

`default_nettype wire

// File: rtl/ex_mem_pipe_buffer.sv
// ============================================================================
// Module : ex_mem_pipe_buffer
// Brief  : EX->MEM pipeline register with 2-entry skid, flush and stall count.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module ex_mem_pipe_buffer
  import ex_mem_pipe_buffer_pkg::*;
#(
  parameter int ADDR_WIDTH      = REGS_ADDR_WIDTH,
  parameter int DATA_WIDTH      = REGS_DATA_WIDTH,
  parameter bit HILO_EN         = 1'b1,
  parameter int STALL_CNT_WIDTH = 16
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       flush,
  input  logic                       ex_valid,
  output logic                       ex_ready,
  input  logic                       ex_write_enable,
  input  logic [ADDR_WIDTH-1:0]      ex_write_addr,
  input  logic [DATA_WIDTH-1:0]      ex_write_data,
  input  logic                       ex_hilo_enable,
  input  logic [DATA_WIDTH-1:0]      ex_hi,
  input  logic [DATA_WIDTH-1:0]      ex_lo,
  output logic                       mem_valid,
  input  logic                       mem_ready,
  output logic                       mem_write_enable,
  output logic [ADDR_WIDTH-1:0]      mem_write_addr,
  output logic [DATA_WIDTH-1:0]      mem_write_data,
  output logic                       mem_hilo_enable,
  output logic [DATA_WIDTH-1:0]      mem_hi,
  output logic [DATA_WIDTH-1:0]      mem_lo,
  output logic [1:0]                 occupancy,
  output logic [STALL_CNT_WIDTH-1:0] stall_cycles
);

  // Payload layout, LSB first: lo, hi, hilo_enable, data, addr, write_enable.
  localparam int HI_LSB = DATA_WIDTH;
  localparam int HE_BIT = 2 * DATA_WIDTH;
  localparam int D_LSB  = HE_BIT + 1;
  localparam int A_LSB  = D_LSB + DATA_WIDTH;
  localparam int WE_BIT = A_LSB + ADDR_WIDTH;
  localparam int PAY_W  = WE_BIT + 1;

  buf_state_e                 state_q, state_d;
  logic                       ex_ready_q, mem_valid_q;
  logic [1:0]                 occupancy_q;
  logic [STALL_CNT_WIDTH-1:0] stall_q, stall_d;

  logic [PAY_W-1:0] ex_pay, head_in, head_q, skid_q;
  logic             push, pop;
  logic             head_load, head_clr, head_from_skid;
  logic             skid_load, skid_clr;

  generate
    if (HILO_EN) begin : g_hilo_on
      assign ex_pay = {ex_write_enable, ex_write_addr, ex_write_data,
                       ex_hilo_enable, ex_hi, ex_lo};
      assign mem_hilo_enable = head_q[HE_BIT] & mem_valid_q;
      assign mem_hi          = head_q[HI_LSB +: DATA_WIDTH];
      assign mem_lo          = head_q[0 +: DATA_WIDTH];
    end else begin : g_hilo_off
      // HI/LO bits stay constant zero, so their flops collapse in synthesis.
      assign ex_pay = {ex_write_enable, ex_write_addr, ex_write_data,
                       1'b0, {(2 * DATA_WIDTH){1'b0}}};
      assign mem_hilo_enable = 1'b0;
      assign mem_hi          = '0;
      assign mem_lo          = '0;
    end
  endgenerate

  assign push = ex_valid & ex_ready_q;
  assign pop  = mem_valid_q & mem_ready;

  always_comb begin
    state_d        = state_q;
    head_load      = 1'b0;
    head_clr       = 1'b0;
    head_from_skid = 1'b0;
    skid_load      = 1'b0;
    skid_clr       = 1'b0;
    if (reset == ENABLE || flush) begin
      state_d  = BUF_EMPTY;
      head_clr = 1'b1;
      skid_clr = 1'b1;
    end else begin
      case (state_q)
        BUF_EMPTY: if (push) begin
          state_d   = BUF_ONE;
          head_load = 1'b1;
        end
        BUF_ONE: begin
          if (push && pop) begin
            head_load = 1'b1;
          end else if (push) begin
            state_d   = BUF_FULL;
            skid_load = 1'b1;
          end else if (pop) begin
            state_d  = BUF_EMPTY;
            head_clr = 1'b1;
          end
        end
        BUF_FULL: if (pop) begin
          state_d        = BUF_ONE;
          head_load      = 1'b1;
          head_from_skid = 1'b1;
          skid_clr       = 1'b1;
        end
        default: begin
          state_d  = BUF_EMPTY;
          head_clr = 1'b1;
          skid_clr = 1'b1;
        end
      endcase
    end
  end

  always_comb begin
    stall_d = stall_q;
    if (mem_valid_q && !mem_ready && (stall_q != {STALL_CNT_WIDTH{1'b1}})) begin
      stall_d = stall_q + 1'b1;
    end
  end

  assign head_in = head_from_skid ? skid_q : ex_pay;

  always_ff @(posedge clock) begin
    if (reset == ENABLE) begin
      state_q     <= BUF_EMPTY;
      ex_ready_q  <= 1'b1;
      mem_valid_q <= 1'b0;
      occupancy_q <= 2'd0;
      stall_q     <= '0;
    end else begin
      state_q     <= state_d;
      ex_ready_q  <= (state_d != BUF_FULL);
      mem_valid_q <= (state_d != BUF_EMPTY);
      occupancy_q <= (state_d == BUF_FULL) ? 2'd2 :
                     (state_d == BUF_ONE)  ? 2'd1 : 2'd0;
      stall_q     <= stall_d;
    end
  end

  pipe_payload_reg #(.WIDTH(PAY_W)) u_head (
    .clock (clock),
    .clear (head_clr),
    .load  (head_load),
    .d_in  (head_in),
    .q_out (head_q)
  );

  pipe_payload_reg #(.WIDTH(PAY_W)) u_skid (
    .clock (clock),
    .clear (skid_clr),
    .load  (skid_load),
    .d_in  (ex_pay),
    .q_out (skid_q)
  );

  assign ex_ready         = ex_ready_q;
  assign mem_valid        = mem_valid_q;
  assign mem_write_enable = head_q[WE_BIT] & mem_valid_q;
  assign mem_write_addr   = head_q[A_LSB +: ADDR_WIDTH];
  assign mem_write_data   = head_q[D_LSB +: DATA_WIDTH];
  assign occupancy        = occupancy_q;
  assign stall_cycles     = stall_q;

endmodule

`default_nettype wire

// File: doc/ex_mem_pipe_buffer.md
Name: ex_mem_pipe_buffer

Overview:
Parametrised EX→MEM pipeline register with a valid/ready handshake, a 2-entry skid buffer, synchronous flush and a saturating stall counter. Carries the GPR write-back triple plus an optional HI/LO write pair. It sits between the execute stage and the memory stage, where the single-register EX/MEM latch was before. It lets MEM back-pressure EX without losing an instruction, and lets the hazard/exception unit squash in-flight work.

Parameters:
ADDR_WIDTH, 5, GPR address width
DATA_WIDTH, 32, GPR/HI/LO data width
HILO_EN, 1, 1 = HI/LO channel present; 0 = HI/LO outputs tied to 0, storage removed
STALL_CNT_WIDTH, 16, width of the stall counter

Ports:
clock  in  1  rising-edge clock
reset  in  1  synchronous, active-high (`ENABLE`) reset
flush  in  1  synchronous squash of all held entries
ex_valid  in  1  EX presents an instruction
ex_ready  out  1  buffer can accept this cycle
ex_write_enable  in  1  GPR write request
ex_write_addr  in  ADDR_WIDTH  GPR destination
ex_write_data  in  DATA_WIDTH  GPR result
ex_hilo_enable  in  1  HI/LO write request
ex_hi  in  DATA_WIDTH  HI result
ex_lo  in  DATA_WIDTH  LO result
mem_valid  out  1  head entry valid
mem_ready  in  1  MEM consumes head this cycle
mem_write_enable  out  1  head GPR write enable, gated by mem_valid
mem_write_addr  out  ADDR_WIDTH  head GPR destination
mem_write_data  out  DATA_WIDTH  head GPR result
mem_hilo_enable  out  1  head HI/LO enable, gated by mem_valid
mem_hi  out  DATA_WIDTH  head HI
mem_lo  out  DATA_WIDTH  head LO
occupancy  out  2  entries held (0..2)
stall_cycles  out  STALL_CNT_WIDTH  saturating count of cycles with mem_valid=1 and mem_ready=0

Behaviour:
- Reset (sync, `ENABLE`), applied at the clock edge:
  - state EMPTY; both entries invalid; all payload registers 0.
  - Outputs: ex_ready=1; mem_valid=0; every mem_* output 0; occupancy=0; stall_cycles=0.
- Handshakes:
  - push = ex_valid & ex_ready.
  - pop = mem_valid & mem_ready.
  - ex_ready is a registered output: 1 exactly when state≠FULL. It has no combinational path from mem_ready.
- Storage: HEAD register drives the mem_* outputs; SKID register holds the second entry. Latency EX→MEM is 1 cycle when empty.
- FSM transitions, each evaluated at the clock edge:
  - EMPTY: push → ONE, HEAD←in. Otherwise stay.
  - ONE, push & pop → ONE, HEAD←in.
  - ONE, push & !pop → FULL, SKID←in.
  - ONE, !push & pop → EMPTY, HEAD←0.
  - ONE, neither → hold.
  - FULL (ex_ready=0, push impossible): pop → ONE, HEAD←SKID, SKID←0. Otherwise hold.
- Order is preserved: SKID is always younger than HEAD.
- flush:
  - Priority is below reset and above every push/pop.
  - Next state EMPTY; all payload zeroed.
  - An input presented in the same cycle is dropped.
  - A pop in the same cycle still counts as consumed by MEM.
  - stall_cycles is not cleared.
- mem_write_enable and mem_hilo_enable are 0 whenever mem_valid=0. Payload is also zero when invalid.
- stall_cycles increments on every cycle with mem_valid & !mem_ready, including the flush cycle. It saturates at 2^STALL_CNT_WIDTH-1 and is cleared only by reset.
- HILO_EN=0: ex_hilo_enable/ex_hi/ex_lo are ignored; the matching outputs are constant 0.
- occupancy: EMPTY=0, ONE=1, FULL=2.

Decomposition:
- Shared package/macro header (macro.v):
  - `ENABLE`/`DISABLE`, REGS_ADDR/DATA widths.
  - State encodings BUF_EMPTY=2'd0, BUF_ONE=2'd1, BUF_FULL=2'd2.
  - Zero-word constant.
- Sub-module pipe_payload_reg: one clocked payload register with load-enable and clear, instantiated for HEAD and SKID. The FSM, handshake and counter stay in the top module.

Test Plan:
- Reset then stream: ex_valid=1, mem_ready=1, writes (r3,0x11),(r4,0x22),(r5,0x33) on consecutive cycles → each appears on mem_* exactly 1 cycle later; ex_ready stays 1; occupancy stays 1.
- Back-pressure: push (r1,0xA), (r2,0xB) with mem_ready=0 → occupancy 2, ex_ready=0. Then mem_ready=1 → r1/0xA pops, then r2/0xB; no loss, no duplication; stall_cycles equals the held-cycle count.
- Flush in FULL with ex_valid=1 carrying (r7,0xC) → next cycle mem_valid=0, mem_write_enable=0, occupancy=0, ex_ready=1; r7 is never seen at MEM.
- HI/LO: ex_hilo_enable=1, hi=0xDEAD0000, lo=0x0000BEEF → mem_hi/mem_lo match 1 cycle later. With HILO_EN=0 the same stimulus gives 0/0/0.
- Stall saturation, STALL_CNT_WIDTH=4: hold mem_valid=1 with mem_ready=0 for 20 cycles → stall_cycles reads 15 and stays at 15.
- Reset mid-operation while FULL → next cycle every output equals its reset value; a push on the following cycle is accepted normally.
